// File: rtl/elevator_switch_hub.sv
// elevator_switch_hub
//
// Command side of the elevator interface. Raw player-on-switch contact flags
// are debounced against the vertical-sync frame tick, then combined into one
// `on` command per elevator. Button switches act momentarily (held while
// pressed). Lever switches toggle a per-elevator latch, and a toggle requested
// while the elevator is still travelling is parked until it arrives.
//
// Build option:
//   ELEVATOR_SWITCH_HUB_LEVER_EN  - when defined, switches flagged in
//                                   LEVER_MASK behave as toggle levers. When
//                                   undefined, every switch is a button and
//                                   elevator_pending is tied low.
//
// Ports:
//   Clk              in   system clock
//   Reset            in   synchronous active-high reset
//   frame_clk        in   frame clock level (asynchronous to Clk)
//   switch_contact   in   raw contact flag per switch
//   elevator_stable  in   elevator e is at rest at an endpoint
//   switch_state     out  debounced pressed flag per switch
//   elevator_on      out  1 = send elevator to end, 0 = send to start
//   elevator_pending out  a lever toggle is waiting for the elevator to arrive
module elevator_switch_hub #(
    parameter int                          SWITCH_COUNT    = 4,
    parameter int                          ELEVATOR_COUNT  = 2,
    parameter logic [4*SWITCH_COUNT-1:0]   SWITCH_TARGET   = 16'h1100,
    parameter logic [SWITCH_COUNT-1:0]     LEVER_MASK      = 4'b1000,
    parameter int                          DEBOUNCE_FRAMES = 3
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_clk,
    input  logic [SWITCH_COUNT-1:0]   switch_contact,
    input  logic [ELEVATOR_COUNT-1:0] elevator_stable,
    output logic [SWITCH_COUNT-1:0]   switch_state,
    output logic [ELEVATOR_COUNT-1:0] elevator_on,
    output logic [ELEVATOR_COUNT-1:0] elevator_pending
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_t;

    localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_FRAMES);

`ifdef ELEVATOR_SWITCH_HUB_LEVER_EN
    localparam logic [SWITCH_COUNT-1:0] LEVER_EFF = LEVER_MASK;
`else
    localparam logic [SWITCH_COUNT-1:0] LEVER_EFF = '0;
`endif

    logic                      delayed;
    logic                      tick;
    deb_state_t                state      [SWITCH_COUNT];
    deb_state_t                state_next [SWITCH_COUNT];
    logic [3:0]                cnt        [SWITCH_COUNT];
    logic [3:0]                cnt_next   [SWITCH_COUNT];
    logic [SWITCH_COUNT-1:0]   press_evt;
    logic [ELEVATOR_COUNT-1:0] button_hold;

    // Counter never wraps: it sticks at the debounce limit.
    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        return (value == DEB_LIMIT) ? value : value + 4'd1;
    endfunction

    // Switch i drives elevator e only when its packed index equals e; an
    // index at or beyond ELEVATOR_COUNT therefore matches nothing.
    function automatic logic targets(input int sw, input int ev);
        return int'(SWITCH_TARGET[4*sw +: 4]) == ev;
    endfunction

    // Frame tick: one-cycle pulse on the first Clk sample of a frame_clk high.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            delayed <= 1'b0;
            tick    <= 1'b0;
        end else begin
            delayed <= frame_clk;
            tick    <= frame_clk & ~delayed;
        end
    end

    // Debounce state and counter registers for every switch.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < SWITCH_COUNT; i++) begin
            if (Reset) begin
                state[i] <= RELEASED;
                cnt[i]   <= '0;
            end else begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
        end
    end

    // Debounce next-state logic. The transition is taken on the tick that
    // brings the count to the limit, so the debounced state changes in the
    // cycle right after that tick.
    always_comb begin
        for (int i = 0; i < SWITCH_COUNT; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            press_evt[i]  = 1'b0;
            case (state[i])
                RELEASED: begin
                    if (switch_contact[i]) begin
                        state_next[i] = PRESS_WAIT;
                        cnt_next[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!switch_contact[i]) begin
                        state_next[i] = RELEASED;
                        cnt_next[i]   = '0;
                    end else if (tick) begin
                        cnt_next[i] = sat_inc(cnt[i]);
                        if (sat_inc(cnt[i]) == DEB_LIMIT) begin
                            state_next[i] = PRESSED;
                            press_evt[i]  = 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!switch_contact[i]) begin
                        state_next[i] = RELEASE_WAIT;
                        cnt_next[i]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (switch_contact[i]) begin
                        state_next[i] = PRESSED;
                    end else if (tick) begin
                        cnt_next[i] = sat_inc(cnt[i]);
                        if (sat_inc(cnt[i]) == DEB_LIMIT) begin
                            state_next[i] = RELEASED;
                        end
                    end
                end
                default: begin
                    state_next[i] = RELEASED;
                    cnt_next[i]   = '0;
                end
            endcase
            switch_state[i] = (state[i] == PRESSED) || (state[i] == RELEASE_WAIT);
        end
    end

    // Momentary hold: any pressed button aimed at the elevator keeps it on.
    always_comb begin
        for (int e = 0; e < ELEVATOR_COUNT; e++) begin
            button_hold[e] = 1'b0;
            for (int i = 0; i < SWITCH_COUNT; i++) begin
                if (targets(i, e) && !LEVER_EFF[i]) begin
                    button_hold[e] = button_hold[e] | switch_state[i];
                end
            end
        end
    end

`ifdef ELEVATOR_SWITCH_HUB_LEVER_EN
    logic [ELEVATOR_COUNT-1:0] lever_evt;
    logic [ELEVATOR_COUNT-1:0] latch;
    logic [ELEVATOR_COUNT-1:0] pending;

    // Lever presses aimed at the same elevator merge into one event.
    always_comb begin
        for (int e = 0; e < ELEVATOR_COUNT; e++) begin
            lever_evt[e] = 1'b0;
            for (int i = 0; i < SWITCH_COUNT; i++) begin
                if (targets(i, e) && LEVER_EFF[i]) begin
                    lever_evt[e] = lever_evt[e] | press_evt[i];
                end
            end
        end
    end

    // A parked toggle takes priority: once the elevator arrives it is applied
    // exactly once, swallowing any event that lands in that same cycle.
    always_ff @(posedge Clk) begin
        for (int e = 0; e < ELEVATOR_COUNT; e++) begin
            if (Reset) begin
                latch[e]   <= 1'b0;
                pending[e] <= 1'b0;
            end else if (pending[e]) begin
                if (elevator_stable[e]) begin
                    latch[e]   <= ~latch[e];
                    pending[e] <= 1'b0;
                end
            end else if (lever_evt[e]) begin
                if (elevator_stable[e]) begin
                    latch[e] <= ~latch[e];
                end else begin
                    pending[e] <= 1'b1;
                end
            end
        end
    end

    // Pending is registered alongside the command so it drops in the same
    // cycle the resulting elevator_on change becomes visible.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            elevator_on      <= '0;
            elevator_pending <= '0;
        end else begin
            elevator_on      <= latch | button_hold;
            elevator_pending <= pending;
        end
    end
`else
    logic unused_lever_inputs;

    assign unused_lever_inputs = ^{elevator_stable, press_evt, LEVER_MASK};
    assign elevator_pending    = '0;

    // Without levers the command is simply the registered button hold.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            elevator_on <= '0;
        end else begin
            elevator_on <= button_hold;
        end
    end
`endif

endmodule

// File: tb/tb_elevator_switch_hub.sv
// tb_elevator_switch_hub
//
// Directed bench for elevator_switch_hub with default parameters. Inputs are
// driven and outputs sampled on the falling edge of Clk. Lever scenarios are
// exercised when ELEVATOR_SWITCH_HUB_LEVER_EN is defined; otherwise the
// all-button behaviour of switch 3 is checked instead.
module tb_elevator_switch_hub;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [3:0] switch_contact;
    logic [1:0] elevator_stable;
    logic [3:0] switch_state;
    logic [1:0] elevator_on;
    logic [1:0] elevator_pending;

    int checks   = 0;
    int failures = 0;

    elevator_switch_hub dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .frame_clk        (frame_clk),
        .switch_contact   (switch_contact),
        .elevator_stable  (elevator_stable),
        .switch_state     (switch_state),
        .elevator_on      (elevator_on),
        .elevator_pending (elevator_pending)
    );

    always #5 Clk = ~Clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // One frame: high for one Clk cycle, low for one. On return the tick has
    // been consumed by the debounce logic.
    task automatic frameTick(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            @(negedge Clk);
            frame_clk = 1'b0;
            @(negedge Clk);
        end
    endtask

    // Change one contact and let the FSM leave its idle state.
    task automatic applyStimulus(input int idx, input logic value);
        switch_contact[idx] = value;
        @(negedge Clk);
    endtask

    initial begin
        Reset           = 1'b1;
        frame_clk       = 1'b0;
        switch_contact  = '0;
        elevator_stable = '0;
        idle(2);
        checkOutput("reset_switch_state", 32'(switch_state), 32'h0);
        checkOutput("reset_elevator_on", 32'(elevator_on), 32'h0);
        checkOutput("reset_pending", 32'(elevator_pending), 32'h0);
        Reset = 1'b0;
        idle(2);

        // Button press on switch 0 (elevator 0), then release.
        applyStimulus(0, 1'b1);
        frameTick(2);
        checkOutput("btn_after_tick2", 32'(switch_state), 32'h0);
        frameTick(1);
        checkOutput("btn_state_rise", 32'(switch_state), 32'h1);
        checkOutput("btn_on_not_yet", 32'(elevator_on), 32'h0);
        idle(1);
        checkOutput("btn_on_rise", 32'(elevator_on), 32'h1);
        applyStimulus(0, 1'b0);
        checkOutput("btn_state_held_release_wait", 32'(switch_state), 32'h1);
        frameTick(2);
        checkOutput("btn_release_tick2", 32'(switch_state), 32'h1);
        frameTick(1);
        checkOutput("btn_state_fall", 32'(switch_state), 32'h0);
        checkOutput("btn_on_still_high", 32'(elevator_on), 32'h1);
        idle(1);
        checkOutput("btn_on_fall", 32'(elevator_on), 32'h0);

        // Bounce rejection on switch 2 (button for elevator 1).
        applyStimulus(2, 1'b1);
        frameTick(2);
        applyStimulus(2, 1'b0);
        applyStimulus(2, 1'b1);
        frameTick(2);
        checkOutput("bounce_state", 32'(switch_state), 32'h0);
        idle(1);
        checkOutput("bounce_on", 32'(elevator_on), 32'h0);
        frameTick(1);
        checkOutput("bounce_third_tick_press", 32'(switch_state), 32'h4);
        idle(1);
        checkOutput("bounce_on_after_press", 32'(elevator_on), 32'h2);
        applyStimulus(2, 1'b0);
        frameTick(3);
        idle(1);
        checkOutput("bounce_cleared", 32'({switch_state, elevator_on}), 32'h0);

`ifdef ELEVATOR_SWITCH_HUB_LEVER_EN
        // Lever while elevator 1 is stable: press toggles, release holds.
        elevator_stable[1] = 1'b1;
        applyStimulus(3, 1'b1);
        frameTick(3);
        checkOutput("lever_state_rise", 32'(switch_state), 32'h8);
        checkOutput("lever_on_not_yet", 32'(elevator_on), 32'h0);
        idle(1);
        checkOutput("lever_on_toggle1", 32'(elevator_on), 32'h2);
        checkOutput("lever_no_pending", 32'(elevator_pending), 32'h0);
        applyStimulus(3, 1'b0);
        frameTick(3);
        idle(2);
        checkOutput("lever_hold_after_release", 32'(elevator_on), 32'h2);
        applyStimulus(3, 1'b1);
        frameTick(3);
        idle(1);
        checkOutput("lever_on_toggle2", 32'(elevator_on), 32'h0);
        applyStimulus(3, 1'b0);
        frameTick(3);
        idle(1);

        // Lever while elevator 1 is moving: toggle parks until arrival.
        elevator_stable[1] = 1'b0;
        applyStimulus(3, 1'b1);
        frameTick(3);
        idle(1);
        checkOutput("moving_pending_set", 32'(elevator_pending), 32'h2);
        checkOutput("moving_on_unchanged", 32'(elevator_on), 32'h0);
        applyStimulus(3, 1'b0);
        frameTick(3);
        applyStimulus(3, 1'b1);
        frameTick(3);
        idle(2);
        checkOutput("moving_second_press_ignored",
                    32'({elevator_pending, elevator_on}), 32'h8);
        applyStimulus(3, 1'b0);
        frameTick(3);
        elevator_stable[1] = 1'b1;
        idle(1);
        checkOutput("arrive_on_before", 32'(elevator_on), 32'h0);
        idle(1);
        checkOutput("arrive_on_toggled", 32'(elevator_on), 32'h2);
        checkOutput("arrive_pending_clear", 32'(elevator_pending), 32'h0);
        idle(4);
        checkOutput("arrive_single_toggle", 32'(elevator_on), 32'h2);

        // Park another toggle so reset has latch and pending to discard.
        elevator_stable[1] = 1'b0;
        applyStimulus(3, 1'b1);
        frameTick(3);
        applyStimulus(3, 1'b0);
        frameTick(3);
        idle(1);
        checkOutput("pre_reset_lever", 32'({elevator_pending, elevator_on}), 32'hA);
`else
        // All-button build: switch 3 is momentary and nothing is ever pending.
        elevator_stable[1] = 1'b1;
        applyStimulus(3, 1'b1);
        frameTick(3);
        checkOutput("nolever_state_rise", 32'(switch_state), 32'h8);
        idle(1);
        checkOutput("nolever_on_rise", 32'(elevator_on), 32'h2);
        checkOutput("nolever_pending_zero", 32'(elevator_pending), 32'h0);
        elevator_stable[1] = 1'b0;
        applyStimulus(3, 1'b0);
        frameTick(3);
        checkOutput("nolever_state_fall", 32'(switch_state), 32'h0);
        idle(1);
        checkOutput("nolever_on_fall", 32'(elevator_on), 32'h0);
        checkOutput("nolever_pending_still_zero", 32'(elevator_pending), 32'h0);
`endif

        // Reset mid-operation: switch 1 pressed, switch 0 part-way debounced.
        applyStimulus(1, 1'b1);
        frameTick(3);
        idle(1);
        checkOutput("pre_reset_sw1_on", 32'(elevator_on[0]), 32'h1);
        applyStimulus(0, 1'b1);
        frameTick(2);
        Reset = 1'b1;
        idle(1);
        Reset = 1'b0;
        checkOutput("midreset_state", 32'(switch_state), 32'h0);
        checkOutput("midreset_on", 32'(elevator_on), 32'h0);
        checkOutput("midreset_pending", 32'(elevator_pending), 32'h0);
        idle(1);
        frameTick(2);
        checkOutput("postreset_two_ticks", 32'(switch_state), 32'h0);
        frameTick(1);
        checkOutput("postreset_three_ticks", 32'(switch_state), 32'h3);
        idle(1);
        checkOutput("postreset_on", 32'({elevator_pending, elevator_on}), 32'h1);
        switch_contact = '0;
        idle(1);
        frameTick(3);
        idle(1);
        checkOutput("final_idle", 32'({switch_state, elevator_on}), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
